// File: rtl/program_sequencer.sv
// Program sequencer with a RUN/HALT control FSM.
// It provides single-step debug, jump counting and detection of sequential address rollover.
module program_sequencer (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic       jmp,
  input  logic       jmp_nz,
  input  logic [3:0] jump_addr,
  input  logic       dont_jmp,
  input  logic       hold,
  input  logic       step,
  output logic [7:0] pm_addr,
  output logic [7:0] pc,
  output logic [7:0] from_PS,
  output logic       halted,
  output logic       wrap,
  output logic [7:0] jmp_count
);

  localparam logic STATE_RUN  = 1'b0;
  localparam logic STATE_HALT = 1'b1;

  logic       state_q, state_d;
  logic [7:0] pc_q;
  logic       stepPrev_q;
  logic       wrap_q, wrap_d;
  logic [7:0] jmpCount_q, jmpCount_d;

  logic stepPulse;
  logic advance;
  logic jumpReq;
  logic jumpTaken;

  assign stepPulse = step & ~stepPrev_q;
  assign advance   = (state_q == STATE_RUN) ? 1'b1 : stepPulse;
  assign jumpReq   = jmp | (jmp_nz & ~dont_jmp);
  assign jumpTaken = ~sync_reset & advance & jumpReq;

  // Reset forces address zero regardless of everything else; a stalled
  // sequencer re-presents the current pc so the fetch is repeated.
  always_comb begin
    pm_addr = pc_q + 8'd1;
    if (sync_reset) begin
      pm_addr = 8'h00;
    end else if (!advance) begin
      pm_addr = pc_q;
    end else if (jumpReq) begin
      pm_addr = {jump_addr, 4'h0};
    end
  end

  always_comb begin
    state_d    = state_q;
    jmpCount_d = jmpCount_q;
    wrap_d     = ~sync_reset & advance & ~jumpReq & (pc_q == 8'hFF);
    if (state_q == STATE_RUN && hold) begin
      state_d = STATE_HALT;
    end else if (state_q == STATE_HALT && !hold) begin
      state_d = STATE_RUN;
    end
    if (jumpTaken && jmpCount_q != 8'hFF) begin
      jmpCount_d = jmpCount_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q    <= STATE_RUN;
      pc_q       <= 8'h00;
      stepPrev_q <= 1'b0;
      wrap_q     <= 1'b0;
      jmpCount_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      pc_q       <= pm_addr;
      stepPrev_q <= step;
      wrap_q     <= wrap_d;
      jmpCount_q <= jmpCount_d;
    end
  end

  assign pc        = pc_q;
  assign from_PS   = pc_q;
  assign halted    = (state_q == STATE_HALT);
  assign wrap      = wrap_q;
  assign jmp_count = jmpCount_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer.
// Inputs change 1ns after each rising edge, and outputs are checked at that same point.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jump_addr;
  logic       dont_jmp;
  logic       hold;
  logic       step;
  logic [7:0] pm_addr;
  logic [7:0] pc;
  logic [7:0] from_PS;
  logic       halted;
  logic       wrap;
  logic [7:0] jmp_count;

  int nChecks = 0;
  int nErrors = 0;

  program_sequencer dut (
    .clk(clk),
    .sync_reset(sync_reset),
    .jmp(jmp),
    .jmp_nz(jmp_nz),
    .jump_addr(jump_addr),
    .dont_jmp(dont_jmp),
    .hold(hold),
    .step(step),
    .pm_addr(pm_addr),
    .pc(pc),
    .from_PS(from_PS),
    .halted(halted),
    .wrap(wrap),
    .jmp_count(jmp_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iJmp, input logic iJmpNz, input logic [3:0] iAddr,
                               input logic iDontJmp, input logic iHold, input logic iStep);
    jmp       = iJmp;
    jmp_nz    = iJmpNz;
    jump_addr = iAddr;
    dont_jmp  = iDontJmp;
    hold      = iHold;
    step      = iStep;
  endtask

  initial begin
    sync_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_pc", pc, 8'h00);
    checkOutput("reset_halted", {7'd0, halted}, 8'h00);
    checkOutput("reset_wrap", {7'd0, wrap}, 8'h00);
    checkOutput("reset_count", jmp_count, 8'h00);

    // Reset must dominate a pending jump, both combinationally and at the edge
    applyStimulus(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset_pm_addr", pm_addr, 8'h00);
    tick();
    checkOutput("reset_jmp_pc", pc, 8'h00);
    checkOutput("reset_jmp_count", jmp_count, 8'h00);

    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    sync_reset = 1'b0;
    #1;
    checkOutput("seq_pm_addr", pm_addr, 8'h01);
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput("seq_pc", pc, 8'(i));
      checkOutput("seq_from_ps", from_PS, 8'(i));
    end
    checkOutput("seq_halted", {7'd0, halted}, 8'h00);
    checkOutput("seq_wrap", {7'd0, wrap}, 8'h00);

    applyStimulus(1'b1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("jmp_pm_addr", pm_addr, 8'hA0);
    tick();
    checkOutput("jmp_pc", pc, 8'hA0);
    checkOutput("jmp_count1", jmp_count, 8'h01);

    applyStimulus(1'b1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("both_pc", pc, 8'h10);
    checkOutput("both_count", jmp_count, 8'h02);

    applyStimulus(1'b0, 1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("nz_supp_pc", pc, 8'h11);
    checkOutput("nz_supp_count", jmp_count, 8'h02);

    applyStimulus(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("nz_take_pc", pc, 8'h30);
    checkOutput("nz_take_count", jmp_count, 8'h03);

    // Rollover: jump to F0, then walk sequentially past FF
    applyStimulus(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("f0_pc", pc, 8'hF0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    checkOutput("ff_pc", pc, 8'hFF);
    checkOutput("ff_wrap", {7'd0, wrap}, 8'h00);
    tick();
    checkOutput("wrap_pc", pc, 8'h00);
    checkOutput("wrap_pulse", {7'd0, wrap}, 8'h01);
    tick();
    checkOutput("wrap_after_pc", pc, 8'h01);
    checkOutput("wrap_clear", {7'd0, wrap}, 8'h00);

    applyStimulus(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("jmp0_pc", pc, 8'h00);
    checkOutput("jmp0_wrap", {7'd0, wrap}, 8'h00);
    checkOutput("jmp0_count", jmp_count, 8'h06);

    // Hold / single-step sequence starting from pc=20
    applyStimulus(1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("h20_pc", pc, 8'h20);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("hold_pc", pc, 8'h21);
    checkOutput("hold_halted", {7'd0, halted}, 8'h01);
    applyStimulus(1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("halt_pm_addr", pm_addr, 8'h21);
    tick();
    checkOutput("halt_jmp_pc", pc, 8'h21);
    checkOutput("halt_jmp_count", jmp_count, 8'h07);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("step1_pc", pc, 8'h22);
    tick();
    tick();
    checkOutput("step_held_pc", pc, 8'h22);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("step_low_pc", pc, 8'h22);
    checkOutput("step_halted", {7'd0, halted}, 8'h01);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("resume_pc", pc, 8'h22);
    checkOutput("resume_halted", {7'd0, halted}, 8'h00);
    tick();
    checkOutput("run23_pc", pc, 8'h23);
    tick();
    checkOutput("run24_pc", pc, 8'h24);

    // Reset while halted with a jump pending
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("halt2_halted", {7'd0, halted}, 8'h01);
    sync_reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("rst_halt_pc", pc, 8'h00);
    checkOutput("rst_halt_count", jmp_count, 8'h00);
    checkOutput("rst_halt_halted", {7'd0, halted}, 8'h00);

    sync_reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 254; i++) tick();
    checkOutput("sat_fe", jmp_count, 8'hFE);
    tick();
    checkOutput("sat_ff", jmp_count, 8'hFF);
    for (int i = 0; i < 45; i++) tick();
    checkOutput("sat_hold", jmp_count, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
